// File: rtl/bar_pattern_decoder.sv
// Bar-graph pattern decoder: sync, debounce, classify, report once via valid/ready.
// Define BAR_DEC_SPECIAL_EN to accept the hand / driver-reset / driver-default patterns.
module bar_pattern_decoder #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [9:0] iSW,
  input  logic       iREADY,
  output logic       oVALID,
  output logic [4:0] oCODE,
  output logic       oHAND,
  output logic       oERR
);

  typedef enum logic {
    SETTLE,
    PRESENT
  } state_t;

  typedef struct packed {
    logic       err;
    logic       hand;
    logic [4:0] code;
  } dec_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  logic [9:0]       sync_a;
  logic [9:0]       sync_b;
  logic [9:0]       prev;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       last;
  logic             reported;
  logic             stable;
  logic             load;
  dec_t             dec;
  state_t           state;
  state_t           state_nxt;

  function automatic dec_t decode(input logic [9:0] p);
    dec_t d;
    d.code = 5'h1F;
    d.hand = 1'b0;
    d.err  = 1'b1;
    if (p == 10'd0) begin
      d.code = 5'd0;
      d.err  = 1'b0;
    end
    for (int k = 1; k <= 10; k++) begin
      if (p == 10'((1 << k) - 1)) begin
        d.code = 5'(k);
        d.err  = 1'b0;
      end
    end
    // high-aligned runs mirror the fill codes from the top: n ones -> 20-n
    for (int n = 1; n <= 9; n++) begin
      if (p == 10'(~((1 << (10 - n)) - 1))) begin
        d.code = 5'(20 - n);
        d.err  = 1'b0;
      end
    end
`ifdef BAR_DEC_SPECIAL_EN
    if (p == 10'b1010101010) begin
      d.code = 5'd0;
      d.hand = 1'b1;
      d.err  = 1'b0;
    end
    if (p == 10'b1100110011) begin
      d.code = 5'h1E;
      d.err  = 1'b0;
    end
    if (p == 10'b0011001100) begin
      d.code = 5'h1D;
      d.err  = 1'b0;
    end
`endif
    return d;
  endfunction

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_a <= '0;
      sync_b <= '0;
      prev   <= '0;
      cnt    <= '0;
    end else begin
      sync_a <= iSW;
      sync_b <= sync_a;
      prev   <= sync_b;
      if (sync_b != prev) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // prev has held its value long enough; report only if it is news
  assign stable = (cnt >= CNT_ARM) &&
                  (!reported || (prev != last));
  assign dec    = decode(prev);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SETTLE: begin
        if (stable) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (iREADY) begin
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_comb begin
    oVALID = 1'b0;
    load   = 1'b0;
    unique case (state)
      SETTLE:  load   = stable;
      PRESENT: oVALID = 1'b1;
      default: oVALID = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oCODE    <= '0;
      oHAND    <= 1'b0;
      oERR     <= 1'b0;
      last     <= '0;
      reported <= 1'b0;
    end else if (load) begin
      oCODE    <= dec.code;
      oHAND    <= dec.hand;
      oERR     <= dec.err;
      last     <= prev;
      reported <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bar_pattern_decoder.sv
// Scoreboard bench for bar_pattern_decoder (STABLE_CYCLES=4).
// Honours BAR_DEC_SPECIAL_EN for the alternate-pattern expectation.
module tb_bar_pattern_decoder;

  typedef struct {
    logic [4:0] code;
    logic       hand;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [9:0] sw;
  logic       ready;
  logic       valid;
  logic [4:0] code;
  logic       hand;
  logic       err;

  int   n_checks;
  int   n_fail;
  exp_t q[$];

  logic       prev_v;
  logic [4:0] held_code;
  logic       held_hand;
  logic       held_err;

  bar_pattern_decoder #(
    .STABLE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .iSW(sw),
    .iREADY(ready),
    .oVALID(valid),
    .oCODE(code),
    .oHAND(hand),
    .oERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_rep(input int c, input logic h, input logic e);
    exp_t x;
    x.code = 5'(c);
    x.hand = h;
    x.err  = e;
    q.push_back(x);
  endtask

  task automatic wait_valid(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (valid === 1'b1) seen = 1;
    end
    check(name, seen, 1);
  endtask

  function automatic logic [9:0] pat(input int i);
    logic [9:0] p;
    int n;
    p = '0;
    if (i >= 1 && i <= 10) begin
      for (int b = 0; b < i; b++) p[b] = 1'b1;
    end else if (i > 10) begin
      n = 20 - i;
      for (int b = 0; b < n; b++) p[9 - b] = 1'b1;
    end
    return p;
  endfunction

  // monitor: one pop per new report, then outputs must stay frozen
  initial prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (valid === 1'b1 && prev_v !== 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_report: got code %0d, required no report", code);
      end else begin
        x = q.pop_front();
        check("rep_code", int'(code), int'(x.code));
        check("rep_hand", int'(hand), int'(x.hand));
        check("rep_err", int'(err), int'(x.err));
      end
      held_code = code;
      held_hand = hand;
      held_err  = err;
    end else if (valid === 1'b1) begin
      check("frozen_outputs", int'({code, hand, err}),
            int'({held_code, held_hand, held_err}));
    end
    prev_v = valid;
  end

  initial begin
    int hi_seen;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    ready = 1'b1;
    sw    = 10'b0000011111;
    ticks(2);
    check("reset_valid", int'(valid), 0);
    check("reset_code", int'(code), 0);
    check("reset_hand", int'(hand), 0);
    check("reset_err", int'(err), 0);

    // T1: latency from release
    expect_rep(5, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      check("t1_not_yet", int'(valid), 0);
    end
    tick();
    check("t1_valid_edge6", int'(valid), 1);
    tick();
    check("t1_accepted", int'(valid), 0);
    ticks(8);

    // T2: bouncing input never settles
    hi_seen = 0;
    for (int c = 0; c < 20; c++) begin
      sw = (c % 2 == 1) ? 10'b0000000011 : 10'b0000000001;
      for (int j = 0; j < 2; j++) begin
        tick();
        if (valid === 1'b1) hi_seen++;
      end
    end
    check("t2_no_valid_toggle", hi_seen, 0);
    expect_rep(2, 1'b0, 1'b0);
    ticks(12);

    // T3: held report while input moves on
    ready = 1'b0;
    sw    = 10'b1111111100;
    expect_rep(12, 1'b0, 1'b0);
    wait_valid("t3_wait_12");
    sw = 10'b0000000001;
    expect_rep(1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_held", int'({valid, code}), int'({1'b1, 5'd12}));
    end
    ready = 1'b1;
    tick();
    check("t3_idle_cycle", int'(valid), 0);
    tick();
    check("t3_next_valid", int'(valid), 1);
    check("t3_next_code", int'(code), 1);
    tick();

    // returning to the last reported pattern before acceptance
    ready = 1'b0;
    sw    = 10'b0000000111;
    expect_rep(3, 1'b0, 1'b0);
    wait_valid("t3b_wait_3");
    sw = 10'b0000001111;
    ticks(12);
    sw = 10'b0000000111;
    ticks(12);
    ready = 1'b1;
    ticks(10);
    check("t3b_no_rereport", int'(valid), 0);

    // T4: illegal and alternate patterns
    sw = 10'b0101000000;
    expect_rep(31, 1'b0, 1'b1);
    ticks(12);
    sw = 10'b1010101010;
`ifdef BAR_DEC_SPECIAL_EN
    expect_rep(0, 1'b1, 1'b0);
`else
    expect_rep(31, 1'b0, 1'b1);
`endif
    ticks(12);

    // T5: reset while presenting
    ready = 1'b0;
    sw    = 10'b0001111111;
    expect_rep(7, 1'b0, 1'b0);
    wait_valid("t5_wait_7");
    rst = 1'b1;
    tick();
    check("t5_reset_valid", int'(valid), 0);
    check("t5_reset_code", int'(code), 0);
    rst = 1'b0;
    expect_rep(7, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      tick();
      check("t5_not_yet", int'(valid), 0);
    end
    tick();
    check("t5_rereport", int'(valid), 1);
    ready = 1'b1;
    tick();

    // T6: sweep of every legal code
    sw = 10'b0101010101;
    expect_rep(31, 1'b0, 1'b1);
    ticks(12);
    for (int i = 0; i < 20; i++) begin
      sw = pat(i);
      expect_rep(i, 1'b0, 1'b0);
      ticks(12);
    end

    ticks(10);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
